// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: sequential fetch, branch redirect with a fixed
// wrong-path flush window, stall/imem back-pressure hold and permanent halt.
module pc_sequencer #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned FLUSH_CYCLES = 2      // legal range 1..7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        halt,
    input  logic        imem_ready,
    output logic [63:0] pc_out,
    output logic        imem_req,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misalign_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Counter holds the number of flush cycles still to come after the current one.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [63:0] pc_nxt;
    logic        imem_req_nxt;
    logic        flush_nxt;
    logic        misalign_nxt;
    logic [31:0] stall_cycles_nxt;
    logic [2:0]  flush_cnt, flush_cnt_nxt;
    logic        redirect;
    logic [63:0] target_aligned;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign target_aligned = {branch_target[63:2], 2'b00};
    // A redirect is honoured only while fetching; IDLE and HALT ignore it.
    assign redirect       = branch_taken && ((state == RUN) || (state == FLUSH));

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc_out;
        imem_req_nxt     = imem_req;
        flush_nxt        = flush;
        misalign_nxt     = misalign_err;
        stall_cycles_nxt = stall_cycles;
        flush_cnt_nxt    = flush_cnt;
        fetch_valid      = 1'b0;

        if (redirect) begin
            pc_nxt        = target_aligned;
            flush_nxt     = 1'b1;
            imem_req_nxt  = 1'b1;
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
            if (branch_target[1:0] != 2'b00)
                misalign_nxt = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt    = RUN;
                    imem_req_nxt = 1'b1;
                end
                RUN: begin
                    fetch_valid = imem_ready && !stall && !halt;
                    if (halt) begin
                        state_nxt    = HALT;
                        imem_req_nxt = 1'b0;
                    end else if (stall || !imem_ready) begin
                        stall_cycles_nxt = sat_inc32(stall_cycles);
                    end else begin
                        pc_nxt = pc_out + 64'd4;
                    end
                end
                FLUSH: begin
                    // Wrong-path fetches keep streaming; stall and halt wait for RUN.
                    if (imem_ready)
                        pc_nxt = pc_out + 64'd4;
                    if (flush_cnt == 3'd0) begin
                        flush_nxt = 1'b0;
                        state_nxt = RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 3'd1;
                    end
                end
                HALT: begin
                    imem_req_nxt = 1'b0;
                    flush_nxt    = 1'b0;
                end
                default: begin
                    state_nxt    = IDLE;
                    imem_req_nxt = 1'b0;
                    flush_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pc_out       <= RESET_PC;
            imem_req     <= 1'b0;
            flush        <= 1'b0;
            misalign_err <= 1'b0;
            stall_cycles <= 32'd0;
            flush_cnt    <= 3'd0;
        end else begin
            state        <= state_nxt;
            pc_out       <= pc_nxt;
            imem_req     <= imem_req_nxt;
            flush        <= flush_nxt;
            misalign_err <= misalign_nxt;
            stall_cycles <= stall_cycles_nxt;
            flush_cnt    <= flush_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed per-cycle vectors push expected
// outputs; a monitor pops and compares them mid-cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        halt;
    logic        imem_ready;
    logic [63:0] pc_out;
    logic        imem_req;
    logic        fetch_valid;
    logic        flush;
    logic        misalign_err;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic        req;
        logic        fv;
        logic        fl;
        logic        mis;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];

    pc_sequencer #(.RESET_PC(64'h0), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt         (halt),
        .imem_ready   (imem_ready),
        .pc_out       (pc_out),
        .imem_req     (imem_req),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
        .misalign_err (misalign_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Monitor: inputs change on the falling edge, outputs are sampled 2 time units later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.name, ".pc"},  pc_out,               e.pc);
                check({e.name, ".req"}, 64'(imem_req),        64'(e.req));
                check({e.name, ".fv"},  64'(fetch_valid),     64'(e.fv));
                check({e.name, ".fl"},  64'(flush),           64'(e.fl));
                check({e.name, ".mis"}, 64'(misalign_err),    64'(e.mis));
                check({e.name, ".sc"},  64'(stall_cycles),    64'(e.sc));
            end
        end
    end

    task automatic cyc(input string name, input logic st, input logic bt, input logic [63:0] tgt,
                       input logic hl, input logic rdy, input logic [63:0] pc, input logic req,
                       input logic fv, input logic fl, input logic mis, input logic [31:0] sc);
        exp_t e;
        @(negedge clk);
        reset         = 1'b0;
        stall         = st;
        branch_taken  = bt;
        branch_target = tgt;
        halt          = hl;
        imem_ready    = rdy;
        e.name = name; e.pc = pc; e.req = req; e.fv = fv; e.fl = fl; e.mis = mis; e.sc = sc;
        exp_q.push_back(e);
    endtask

    // Assert reset between edges and check the outputs clear before the next edge.
    task automatic async_reset(input string name);
        #3;
        reset = 1'b1;
        #1;
        check({name, ".pc"},  pc_out,               64'h0);
        check({name, ".req"}, 64'(imem_req),        64'h0);
        check({name, ".fl"},  64'(flush),           64'h0);
        check({name, ".mis"}, 64'(misalign_err),    64'h0);
        check({name, ".sc"},  64'(stall_cycles),    64'h0);
        check({name, ".fv"},  64'(fetch_valid),     64'h0);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
        halt = 1'b0; imem_ready = 1'b1;

        // Reset release and sequential fetch
        cyc("idle",     0,0,64'h0,0,1, 64'h0,   0,0,0,0,0);
        cyc("run0",     0,0,64'h0,0,1, 64'h0,   1,1,0,0,0);
        cyc("run4",     0,0,64'h0,0,1, 64'h4,   1,1,0,0,0);
        cyc("run8",     0,0,64'h0,0,1, 64'h8,   1,1,0,0,0);
        cyc("run12",    0,0,64'h0,0,1, 64'hC,   1,1,0,0,0);
        // Redirect and two-cycle flush
        cyc("br_issue", 0,1,64'h200,0,1, 64'h10,  1,0,0,0,0);
        cyc("flush1",   0,0,64'h0,0,1,   64'h200, 1,0,1,0,0);
        cyc("flush2",   0,0,64'h0,0,1,   64'h204, 1,0,1,0,0);
        cyc("resume",   0,0,64'h0,0,1,   64'h208, 1,1,0,0,0);
        // Stall then imem back-pressure
        cyc("stall1",   1,0,64'h0,0,1, 64'h20C, 1,0,0,0,0);
        cyc("stall2",   1,0,64'h0,0,1, 64'h20C, 1,0,0,0,1);
        cyc("stall3",   1,0,64'h0,0,1, 64'h20C, 1,0,0,0,2);
        cyc("nrdy1",    0,0,64'h0,0,0, 64'h20C, 1,0,0,0,3);
        cyc("nrdy2",    0,0,64'h0,0,0, 64'h20C, 1,0,0,0,4);
        cyc("held5",    0,0,64'h0,0,1, 64'h20C, 1,1,0,0,5);
        // Redirect beats stall; stall ignored inside flush
        cyc("stall_br", 1,1,64'h300,0,1, 64'h210, 1,0,0,0,5);
        cyc("fl_stall", 1,0,64'h0,0,1,   64'h300, 1,0,1,0,5);
        cyc("fl_end",   0,0,64'h0,0,1,   64'h304, 1,0,1,0,5);
        cyc("run308",   0,0,64'h0,0,1,   64'h308, 1,1,0,0,5);
        // Misaligned target
        cyc("mis_br",   0,1,64'h103,0,1, 64'h30C, 1,0,0,0,5);
        cyc("mis_fl1",  0,0,64'h0,0,1,   64'h100, 1,0,1,1,5);
        cyc("mis_fl2",  0,0,64'h0,0,1,   64'h104, 1,0,1,1,5);
        for (int i = 0; i < 10; i++)
            cyc("mis_hold", 0,0,64'h0,0,1, 64'h108 + 64'(4 * i), 1,1,0,1,5);
        // Redirect inside flush, halt deferred until flush ends
        cyc("br400",    0,1,64'h400,0,1, 64'h130, 1,0,0,1,5);
        cyc("rebr500",  0,1,64'h500,0,1, 64'h400, 1,0,1,1,5);
        cyc("fl_halt1", 0,0,64'h0,1,1,   64'h500, 1,0,1,1,5);
        cyc("fl_halt2", 0,0,64'h0,1,1,   64'h504, 1,0,1,1,5);
        cyc("halt_run", 0,0,64'h0,1,1,   64'h508, 1,0,0,1,5);
        cyc("halt_br",  0,1,64'h600,1,1, 64'h508, 0,0,0,1,5);
        cyc("halt_st",  1,0,64'h0,0,0,   64'h508, 0,0,0,1,5);
        cyc("halted",   0,0,64'h0,0,1,   64'h508, 0,0,0,1,5);
        async_reset("rst_halt");
        // PC wrap at the top of the address space
        cyc("idle2",    0,0,64'h0,0,1, 64'h0, 0,0,0,0,0);
        cyc("br_wrap",  0,1,64'hFFFF_FFFF_FFFF_FFF4,0,1, 64'h0, 1,0,0,0,0);
        cyc("wfl1",     0,0,64'h0,0,1, 64'hFFFF_FFFF_FFFF_FFF4, 1,0,1,0,0);
        cyc("wfl2",     0,0,64'h0,0,1, 64'hFFFF_FFFF_FFFF_FFF8, 1,0,1,0,0);
        cyc("wrun",     0,0,64'h0,0,1, 64'hFFFF_FFFF_FFFF_FFFC, 1,1,0,0,0);
        cyc("wrap0",    0,0,64'h0,0,1, 64'h0, 1,1,0,0,0);
        // Reset in the middle of a flush leaves no residue
        cyc("br40",     0,1,64'h40,0,1, 64'h4,  1,0,0,0,0);
        cyc("fl40",     0,0,64'h0,0,1,  64'h40, 1,0,1,0,0);
        async_reset("rst_flush");
        cyc("idle3",    0,0,64'h0,0,1, 64'h0, 0,0,0,0,0);
        cyc("no_fl",    0,0,64'h0,0,1, 64'h0, 1,1,0,0,0);
        cyc("run4b",    0,0,64'h0,0,1, 64'h4, 1,1,0,0,0);

        @(negedge clk);
        #4;
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
